alu_cmp_issuer: RTL and testbench
=================================

// Module: alu_cmp_issuer
// PURPOSE
//  Initiator side of the ALU compare path: accepts tagged operand pairs over a valid/ready
//  handshake, buffers them in a small FIFO and drives them one at a time onto a combinational
//  compare unit (alu_slt/alu_sltu) through registered alu_rs1/alu_rs2. Samples alu_rd after
//  SETTLE cycles and returns result plus tag over a downstream valid/ready handshake.
// PARAMETERS
//  DEPTH   2   operand FIFO entries; power of two, >= 2
//  SETTLE  1   cycles operands are held before alu_rd is sampled; >= 1
//  TAGW    4   width of request tag carried with each operand pair
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst        in   1       asynchronous reset, active-high
//  in_valid   in   1       upstream request valid
//  in_ready   out  1       FIFO can accept (= !full)
//  in_rs1     in   32      operand 1
//  in_rs2     in   32      operand 2
//  in_tag     in   TAGW    request tag
//  alu_rs1    out  32      registered operand 1 to compare unit
//  alu_rs2    out  32      registered operand 2 to compare unit
//  alu_rd     in   32      compare unit result (legal values 0 or 1)
//  out_valid  out  1       result valid, held until accepted
//  out_ready  in   1       downstream accepts result
//  out_rd     out  32      captured alu_rd
//  out_tag    out  TAGW    tag of the request that produced out_rd
//  out_err    out  1       alu_rd[31:1] != 0 at capture; qualifies out_valid
//  busy       out  1       FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; FIFO empty, pointers 0, FSM IDLE, counter 0.
//  - Push when in_valid && in_ready at rising edge. in_ready is registered-state based (!full);
//    a push is never accepted while full, even if a pop occurs the same cycle.
//  - Pop sees registered FIFO contents only: an entry pushed at edge E is poppable at E+1 earliest.
//  - FSM IDLE: FIFO non-empty -> pop head into alu_rs1/alu_rs2/tag reg, cnt<=SETTLE, go WAIT.
//    Empty -> stay; alu_rs1/alu_rs2 hold last values (no toggling).
//  - WAIT: cnt decrements each cycle; on edge where cnt==1, out_rd<=alu_rd, out_tag<=held tag,
//    out_err<=|alu_rd[31:1], out_valid<=1, go HOLD. Pop at edge E -> out_valid high after E+SETTLE.
//  - HOLD: out_valid, out_rd, out_tag, out_err stable until out_valid && out_ready.
//    On accept: FIFO non-empty -> pop next and go WAIT same edge (out_valid drops for SETTLE
//    cycles); empty -> out_valid<=0, go IDLE.
//  - Only one request in flight; results return strictly in push order.
//  - FIFO pointers are log2(DEPTH)+1 bits; wrap on natural overflow; full = MSBs differ, low equal.
//  - Async rst mid-operation: FIFO flushed, in-flight request dropped, out_valid 0 immediately.
//  - busy = !empty || state != IDLE; combinational from registered state.
// TESTING
//  - Responder model alu_rd = $signed(rs1)<$signed(rs2), SETTLE=1: push (2,1,t1),(1,2,t2),
//    (1,1,t3),(-1,1,t4),(-1,-2,t5), out_ready=1 -> rd/tag 0/t1,1/t2,0/t3,1/t4,0/t5 in order.
//  - Latency: single push (1,2) at edge E into empty idle block -> alu_rs1=1,alu_rs2=2 from E+1,
//    out_valid=1,out_rd=1 from E+2; with SETTLE=3 out_valid from E+4.
//  - Backpressure: out_ready=0, push 4 requests, DEPTH=2 -> 1 in HOLD, 2 in FIFO, in_ready=0 for
//    4th until first accept; out_rd/out_tag stable while held; all 4 eventually returned in order.
//  - Error: model returns 32'h0000_0002 for (5,5) -> out_err=1 with out_valid; next (0,1) -> err 0.
//  - Reset mid-op: assert rst while in WAIT with 2 queued -> out_valid,busy=0, in_ready=1 at once;
//    after release, push (-1,1) -> single result 1, no stale results emerge.
//  - Empty-FIFO same-cycle push/drain: accept result and push new pair on same edge -> IDLE for
//    one cycle, then pop; out_valid low exactly SETTLE+1 cycles.

Source files
------------

// File: rtl/alu_cmp_issuer_if.sv
// alu_cmp_issuer_if: request, compare-unit and result signals of the ALU compare issuer.
// Rev 1.0
`default_nettype none

interface alu_cmp_issuer_if #(
    parameter int TAGW = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_rs1;
    logic [31:0]     in_rs2;
    logic [TAGW-1:0] in_tag;
    logic [31:0]     alu_rs1;
    logic [31:0]     alu_rs2;
    logic [31:0]     alu_rd;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_rd;
    logic [TAGW-1:0] out_tag;
    logic            out_err;
    logic            busy;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_tag, alu_rd, out_ready,
        output in_ready, alu_rs1, alu_rs2, out_valid, out_rd, out_tag, out_err, busy
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_tag, alu_rd, out_ready,
        input  in_ready, alu_rs1, alu_rs2, out_valid, out_rd, out_tag, out_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/alu_cmp_issuer.sv
// alu_cmp_issuer: FIFO-buffered issuer of operand pairs to a combinational compare unit.
// Rev 1.0
`default_nettype none

module alu_cmp_issuer #(
    parameter int DEPTH  = 2,
    parameter int SETTLE = 1,
    parameter int TAGW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_cmp_issuer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    logic [31:0]     rs1_mem [DEPTH];
    logic [31:0]     rs2_mem [DEPTH];
    logic [TAGW-1:0] tag_mem [DEPTH];

    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [TAGW-1:0] tag_q, tag_d, otag_q, otag_d;
    logic            ovalid_q, ovalid_d, err_q, err_d;

    logic            empty_w, full_w, push_w, pop_w;
    logic [AW-1:0]   rd_idx_w;

    assign empty_w  = (wr_ptr_q == rd_ptr_q);
    assign full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_w   = bus.in_valid && !full_w;
    assign rd_idx_w = rd_ptr_q[AW-1:0];

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push_w) begin
            rs1_mem[wr_ptr_q[AW-1:0]] <= bus.in_rs1;
            rs2_mem[wr_ptr_q[AW-1:0]] <= bus.in_rs2;
            tag_mem[wr_ptr_q[AW-1:0]] <= bus.in_tag;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        tag_d    = tag_q;
        rd_d     = rd_q;
        otag_d   = otag_q;
        err_d    = err_q;
        ovalid_d = ovalid_q;
        pop_w    = 1'b0;

        case (state_q)
            S_IDLE: begin
                pop_w = !empty_w;
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    rd_d     = bus.alu_rd;
                    otag_d   = tag_q;
                    err_d    = |bus.alu_rd[31:1];
                    ovalid_d = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    ovalid_d = 1'b0;
                    pop_w    = !empty_w;
                    if (empty_w) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop_w) begin
            rs1_d   = rs1_mem[rd_idx_w];
            rs2_d   = rs2_mem[rd_idx_w];
            tag_d   = tag_mem[rd_idx_w];
            cnt_d   = CW'(SETTLE);
            state_d = S_WAIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            tag_q    <= '0;
            rd_q     <= '0;
            otag_q   <= '0;
            err_q    <= 1'b0;
            ovalid_q <= 1'b0;
        end else begin
            if (push_w) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_w)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            tag_q    <= tag_d;
            rd_q     <= rd_d;
            otag_q   <= otag_d;
            err_q    <= err_d;
            ovalid_q <= ovalid_d;
        end
    end

    assign bus.in_ready  = !full_w;
    assign bus.alu_rs1   = rs1_q;
    assign bus.alu_rs2   = rs2_q;
    assign bus.out_valid = ovalid_q;
    assign bus.out_rd    = rd_q;
    assign bus.out_tag   = otag_q;
    assign bus.out_err   = err_q;
    assign bus.busy      = !empty_w || (state_q != S_IDLE);
endmodule

`default_nettype wire

// File: tb/tb_alu_cmp_issuer.sv
// tb_alu_cmp_issuer: directed tests of alu_cmp_issuer against a queue-based result model.
// Rev 1.0
`default_nettype none

module tb_alu_cmp_issuer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmp_issuer_if #(.TAGW(4)) b0 ();
    alu_cmp_issuer_if #(.TAGW(4)) b1 ();

    // Compare unit: signed less-than, except (5,5) which returns an illegal value.
    function automatic logic [31:0] resp(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'd5 && b == 32'd5) return 32'h0000_0002;
        return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endfunction

    assign b0.alu_rd = resp(b0.alu_rs1, b0.alu_rs2);
    assign b1.alu_rd = resp(b1.alu_rs1, b1.alu_rs2);

    alu_cmp_issuer #(.DEPTH(2), .SETTLE(1), .TAGW(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
    alu_cmp_issuer #(.DEPTH(2), .SETTLE(3), .TAGW(4)) u1 (.clk(clk), .rst(rst), .bus(b1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  tag;
        logic        err;
    } res_t;

    res_t exp_q[$];
    res_t log_q[$];

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        res_t r;
        r.rd  = resp(a, b);
        r.tag = t;
        r.err = (r.rd > 32'd1);
        return r;
    endfunction

    // Every accepted request must come back once, in push order, stable while held.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (b0.in_valid && b0.in_ready)
                exp_q.push_back(model(b0.in_rs1, b0.in_rs2, b0.in_tag));
            if (b0.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, b0.out_valid}, 32'd0);
                end else begin
                    chk("out_rd",  b0.out_rd, exp_q[0].rd);
                    chk("out_tag", {28'd0, b0.out_tag}, {28'd0, exp_q[0].tag});
                    chk("out_err", {31'd0, b0.out_err}, {31'd0, exp_q[0].err});
                    if (b0.out_ready) begin
                        log_q.push_back(res_t'{b0.out_rd, b0.out_tag, b0.out_err});
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        int k = 0;
        @(posedge clk); #1;
        b0.in_valid = 1'b1; b0.in_rs1 = a; b0.in_rs2 = b; b0.in_tag = t;
        @(negedge clk);
        while (!b0.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!b0.in_ready) chk("push_timeout", {31'd0, b0.in_ready}, 32'd1);
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("log_count", log_q.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while ((b0.busy || b1.busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle", {30'd0, b0.busy, b1.busy}, 32'd0);
    endtask

    int exp1_rd[5] = '{0, 1, 0, 1, 0};
    int exp3_rd[4] = '{1, 0, 1, 0};

    initial begin
        int n;
        int acc;
        b0.in_valid = 1'b0; b0.in_rs1 = '0; b0.in_rs2 = '0; b0.in_tag = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_rs1 = '0; b1.in_rs2 = '0; b1.in_tag = '0; b1.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, b0.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, b0.out_valid}, 32'd0);
        chk("rst_busy",      {31'd0, b0.busy}, 32'd0);
        chk("rst_alu_rs1",   b0.alu_rs1, 32'd0);
        chk("rst_out_rd",    b0.out_rd, 32'd0);
        chk("rst_out_tag",   {28'd0, b0.out_tag}, 32'd0);
        chk("rst_b1_ready",  {31'd0, b1.in_ready}, 32'd1);
        #1 rst = 1'b0;

        // Ordered signed-compare results
        b0.out_ready = 1'b1;
        push0(32'd2, 32'd1, 4'd1);
        push0(32'd1, 32'd2, 4'd2);
        push0(32'd1, 32'd1, 4'd3);
        push0(32'hFFFF_FFFF, 32'd1, 4'd4);
        push0(32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'd5);
        wait_log(5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) begin
            chk($sformatf("seq_rd%0d", i), log_q[i].rd, exp1_rd[i]);
            chk($sformatf("seq_tag%0d", i), {28'd0, log_q[i].tag}, i + 1);
        end
        log_q.delete();
        wait_idle();

        // Latency, SETTLE=1 on u0 and SETTLE=3 on u1
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        b0.in_valid = 1'b1; b0.in_rs1 = 32'd1; b0.in_rs2 = 32'd2; b0.in_tag = 4'd6;
        b1.in_valid = 1'b1; b1.in_rs1 = 32'd1; b1.in_rs2 = 32'd2; b1.in_tag = 4'd6;
        @(posedge clk); #1;
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_e0_valid", {31'd0, b0.out_valid}, 32'd0);
        chk("lat_e0_busy",  {31'd0, b0.busy}, 32'd1);
        @(negedge clk);
        chk("lat_e1_rs1",    b0.alu_rs1, 32'd1);
        chk("lat_e1_rs2",    b0.alu_rs2, 32'd2);
        chk("lat_e1_valid",  {31'd0, b0.out_valid}, 32'd0);
        chk("lat_e1_b1_rs1", b1.alu_rs1, 32'd1);
        @(negedge clk);
        chk("lat_e2_valid",    {31'd0, b0.out_valid}, 32'd1);
        chk("lat_e2_rd",       b0.out_rd, 32'd1);
        chk("lat_e2_b1_valid", {31'd0, b1.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e3_b1_valid", {31'd0, b1.out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_e4_b1_valid", {31'd0, b1.out_valid}, 32'd1);
        chk("lat_e4_b1_rd",    b1.out_rd, 32'd1);
        log_q.delete();
        wait_idle();

        // Backpressure: one held, two queued, fourth stalled
        b0.out_ready = 1'b0;
        push0(32'd3, 32'd7, 4'd1);
        push0(32'd7, 32'd3, 4'd2);
        push0(32'hFFFF_FFFB, 32'hFFFF_FFFC, 4'd3);
        b0.in_valid = 1'b1; b0.in_rs1 = 32'd0; b0.in_rs2 = 32'd0; b0.in_tag = 4'd4;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, b0.in_ready}, 32'd0);
            chk("bp_held_rd",  b0.out_rd, 32'd1);
            chk("bp_held_tag", {28'd0, b0.out_tag}, 32'd1);
        end
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b0.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_ready_back", {31'd0, b0.in_ready}, 32'd1);
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        wait_log(4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            chk($sformatf("bp_rd%0d", i), log_q[i].rd, exp3_rd[i]);
            chk($sformatf("bp_tag%0d", i), {28'd0, log_q[i].tag}, i + 1);
        end
        log_q.delete();
        wait_idle();

        // Illegal compare result flags out_err
        push0(32'd5, 32'd5, 4'd7);
        push0(32'd0, 32'd1, 4'd8);
        wait_log(2);
        if (log_q.size() >= 2) begin
            chk("err_flag0", {31'd0, log_q[0].err}, 32'd1);
            chk("err_rd0",   log_q[0].rd, 32'h2);
            chk("err_flag1", {31'd0, log_q[1].err}, 32'd0);
            chk("err_rd1",   log_q[1].rd, 32'd1);
        end
        log_q.delete();
        wait_idle();

        // Async reset while u1 is in WAIT with two requests queued
        @(posedge clk); #1;
        b1.in_valid = 1'b1; b1.in_rs1 = 32'd1; b1.in_rs2 = 32'd2; b1.in_tag = 4'd1;
        @(posedge clk); #1;
        b1.in_rs1 = 32'd2; b1.in_rs2 = 32'd1; b1.in_tag = 4'd2;
        @(posedge clk); #1;
        b1.in_rs1 = 32'd3; b1.in_rs2 = 32'd4; b1.in_tag = 4'd3;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        chk("pre_rst_busy",  {31'd0, b1.busy}, 32'd1);
        chk("pre_rst_ready", {31'd0, b1.in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, b1.out_valid}, 32'd0);
        chk("mid_rst_busy",  {31'd0, b1.busy}, 32'd0);
        chk("mid_rst_ready", {31'd0, b1.in_ready}, 32'd1);
        @(negedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        b1.in_valid = 1'b1; b1.in_rs1 = 32'hFFFF_FFFF; b1.in_rs2 = 32'd1; b1.in_tag = 4'd9;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        acc = 0;
        repeat (15) begin
            @(negedge clk);
            if (b1.out_valid && b1.out_ready) begin
                acc++;
                chk("post_rst_rd",  b1.out_rd, 32'd1);
                chk("post_rst_tag", {28'd0, b1.out_tag}, 32'd9);
            end
        end
        chk("post_rst_count", acc, 32'd1);
        wait_idle();

        // Accept and push on the same edge with an empty FIFO
        b0.out_ready = 1'b0;
        push0(32'd1, 32'd2, 4'd10);
        n = 0;
        while (!b0.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("gap_first_valid", {31'd0, b0.out_valid}, 32'd1);
        @(posedge clk); #1;
        b0.out_ready = 1'b1;
        b0.in_valid = 1'b1; b0.in_rs1 = 32'd4; b0.in_rs2 = 32'd3; b0.in_tag = 4'd11;
        @(posedge clk); #1;
        b0.in_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (b0.out_valid) break;
            n++;
        end
        chk("gap_low_cycles", n, 32'd2);
        wait_log(2);
        if (log_q.size() >= 2) begin
            chk("gap_tag0", {28'd0, log_q[0].tag}, 32'd10);
            chk("gap_tag1", {28'd0, log_q[1].tag}, 32'd11);
            chk("gap_rd1",  log_q[1].rd, 32'd0);
        end
        wait_idle();
        chk("final_exp_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
